cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_if.sv | 47 ++++
 rtl/cdb_arbiter.sv | 97 +++++++++
 2 files changed

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if -- bundle of the common-data-bus arbiter signals.
//
// Signals:
//   requires          per-unit broadcast request (bit 3..0 = mem, div, mul, alu)
//   data0..data3      result word of each unit
//   label0..label3    reservation tag of each unit
//   accepts           one-hot grant back to the units (combinational)
//   BCEN              registered broadcast-valid strobe
//   BCdata            registered broadcast data
//   BClabel           registered broadcast tag
//   ptr               current highest-priority requester index (debug)
//
// Modports:
//   master  execution-unit side: drives requests/data/labels, observes the rest
//   slave   arbiter side: consumes requests/data/labels, drives grant and bus
interface cdb_arbiter_if;
  logic [3:0]  requires;
  logic [31:0] data0;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [31:0] data3;
  logic [3:0]  label0;
  logic [3:0]  label1;
  logic [3:0]  label2;
  logic [3:0]  label3;
  logic [3:0]  accepts;
  logic        BCEN;
  logic [31:0] BCdata;
  logic [3:0]  BClabel;
  logic [1:0]  ptr;

  modport master (
    output requires,
    output data0, data1, data2, data3,
    output label0, label1, label2, label3,
    input  accepts,
    input  BCEN, BCdata, BClabel, ptr
  );

  modport slave (
    input  requires,
    input  data0, data1, data2, data3,
    input  label0, label1, label2, label3,
    output accepts,
    output BCEN, BCdata, BClabel, ptr
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter -- four-way common-data-bus arbiter.
//
// Each cycle the first requesting unit at or after ptr (searching upward,
// wrapping 3 -> 0) is granted combinationally on accepts. At the following
// rising edge its data and label are registered onto the broadcast bus with
// BCEN high for exactly that one cycle. Idle cycles drop BCEN and hold the
// last broadcast data/label.
//
// Configuration macro:
//   CDB_ARB_ROUND_ROBIN_EN  defined   : ptr advances to (grant+1) mod 4 on every
//                                       grant, giving round-robin service.
//                           undefined : ptr stays at 0, i.e. fixed priority with
//                                       alu (0) highest down to mem (3).
//
// Ports:
//   clk   rising-edge clock for all state
//   nRST  asynchronous active-low reset (ptr, BCEN, BCdata, BClabel -> 0)
//   bus   cdb_arbiter_if.slave: requires, data0..3, label0..3 in;
//         accepts, BCEN, BCdata, BClabel, ptr out
module cdb_arbiter (
  input  logic           clk,
  input  logic           nRST,
  cdb_arbiter_if.slave   bus
);

  logic [1:0]  ptr_q,     ptr_d;
  logic        bcen_q,    bcen_d;
  logic [31:0] bcdata_q,  bcdata_d;
  logic [3:0]  bclabel_q, bclabel_d;

  logic        grant_vld;
  logic [1:0]  grant_idx;
  logic [1:0]  cand;
  logic [3:0]  accepts_c;
  logic [31:0] sel_data;
  logic [3:0]  sel_label;

  // Grant search: depends only on requires and ptr, never on data/label.
  // The fixed-priority build shares this path with ptr pinned to 0.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = ptr_q;
    cand      = ptr_q;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = ptr_q + k[1:0];
      if (!grant_vld && bus.requires[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    accepts_c = grant_vld ? (4'b0001 << grant_idx) : '0;
  end

  always_comb begin
    sel_data  = bus.data0;
    sel_label = bus.label0;
    case (grant_idx)
      2'd0: begin sel_data = bus.data0; sel_label = bus.label0; end
      2'd1: begin sel_data = bus.data1; sel_label = bus.label1; end
      2'd2: begin sel_data = bus.data2; sel_label = bus.label2; end
      2'd3: begin sel_data = bus.data3; sel_label = bus.label3; end
      default: begin sel_data = bus.data0; sel_label = bus.label0; end
    endcase
  end

  always_comb begin
    bcen_d    = grant_vld;
    bcdata_d  = grant_vld ? sel_data  : bcdata_q;
    bclabel_d = grant_vld ? sel_label : bclabel_q;
`ifdef CDB_ARB_ROUND_ROBIN_EN
    ptr_d     = grant_vld ? (grant_idx + 2'd1) : ptr_q;
`else
    ptr_d     = '0;
`endif
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      ptr_q     <= '0;
      bcen_q    <= 1'b0;
      bcdata_q  <= '0;
      bclabel_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      bcen_q    <= bcen_d;
      bcdata_q  <= bcdata_d;
      bclabel_q <= bclabel_d;
    end
  end

  assign bus.accepts = accepts_c;
  assign bus.BCEN    = bcen_q;
  assign bus.BCdata  = bcdata_q;
  assign bus.BClabel = bclabel_q;
  assign bus.ptr     = ptr_q;

endmodule
